palette_fade_ctrl: RTL and testbench
====================================

// Module: palette_fade_ctrl
// PURPOSE
//  Sequences the palette brightness input for screen fades. CPU programs step, rate and target
//  over the system memory bus; block ramps brightness once per N vsync pulses until target, then
//  flags done. Sits between the memory-mapped bus decoder, the VGA timing block and the palette.
// PARAMETERS
//  RESET_BRIGHTNESS  8'hFF  brightness after reset (FF = full, display visible at boot)
//  DEFAULT_STEP      8'd8   step register reset value
//  DEFAULT_RATE      8'd1   frames-per-step register reset value
// PORTS
//  clk         in   1   system clock; all logic on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  vsync_pulse in   1   1-cycle pulse at start of vertical blank, clk domain
//  memenable   in   1   bus select for this block
//  memaddr     in   2   register index: 0 CONTROL, 1 RATE_STEP, 2 TARGET, 3 STATUS
//  memwrite    in   1   write strobe, qualified by memenable
//  writedata   in   16  bus write data
//  memdata     out  16  registered read data, valid 1 cycle after memenable
//  brightness  out  8   to palette brightness input; registered
//  busy        out  1   high while FADE_IN or FADE_OUT
//  irq         out  1   fade-done interrupt (see CONFIGURATION)
// BEHAVIOUR
//  Reset: brightness=RESET_BRIGHTNESS, step=DEFAULT_STEP, rate=DEFAULT_RATE, target=8'h00,
//   state=IDLE, frame_cnt=0, done=0, memdata=0, busy=0, irq=0.
//  Registers: RATE_STEP {rate[15:8], step[7:0]}; TARGET {8'h00, target[7:0]};
//   STATUS read {done[15], busy[14], state[13:12], 4'h0, brightness[7:0]}; write bit15=1 clears done.
//   CONTROL write cmd=writedata[1:0]: 00 STOP, 01 FADE_IN, 10 FADE_OUT, 11 SET (brightness=writedata[15:8]).
//   CONTROL reads {14'h0, state}. Rate 0 and step 0 are treated as 1.
//  States: IDLE(00), FADE_IN(01), FADE_OUT(10). Encoding 11 unused, decodes to IDLE.
//  Command accept (cycle of CONTROL write): frame_cnt<=0.
//   FADE_IN: if target<=brightness -> IDLE, done<=1 next cycle, brightness unchanged; else FADE_IN.
//   FADE_OUT: if target>=brightness -> IDLE, done<=1; else FADE_OUT.
//   STOP: IDLE, brightness frozen, done unchanged. SET: IDLE, brightness loaded, done unchanged.
//  Stepping: in FADE_x, each vsync_pulse increments frame_cnt; when frame_cnt+1==rate, frame_cnt<=0
//   and a step is applied that cycle (brightness updates next edge).
//   FADE_IN: sum=9-bit brightness+step; brightness<=min(sum,target).
//   FADE_OUT: diff=9-bit brightness-step; brightness<=(diff[8] or diff<target) ? target : diff.
//   brightness==target after step -> IDLE, done<=1 same edge. No wrap-around ever.
//  Step/rate/target writes mid-fade take effect at the next step evaluation; frame_cnt kept.
//  Simultaneous CONTROL write and step-due vsync: write wins, step discarded.
//  Simultaneous done set and STATUS clear write: set wins.
//  Reads have no side effects. busy = (state==FADE_IN | state==FADE_OUT), registered.
//  Reset asserted mid-fade: immediate return to reset values, no done.
// CONFIGURATION
//  PALETTE_FADE_IRQ_EN defined: irq = registered done flag, level, held until cleared via STATUS.
//  Undefined: irq tied 0; done still visible in STATUS for polling.
// TESTING
//  Reset -> brightness=FF, busy=0, irq=0, STATUS read=16'h00FF.
//  SET 0x00, step=0x40 rate=1 target=0xFF, FADE_IN -> brightness 40,80,C0,FF on 4 vsyncs; done.
//  rate=3 step=0x10 FADE_OUT from 0x28 target 0 -> changes only on 3rd,6th,9th vsync: 18,08,00.
//  FADE_OUT with target=0x50 at brightness 0x30 -> IDLE next cycle, done=1, brightness 0x30.
//  CONTROL write coincident with step-due vsync -> no step, frame_cnt=0, new command state.
//  With PALETTE_FADE_IRQ_EN: irq rises with done, falls after STATUS write 16'h8000; without: irq=0.

Source files
------------

// File: rtl/palette_fade_ctrl_if.sv
// Memory-mapped register bus between the system bus decoder (master) and the fade controller (slave).
// Read data is registered inside the slave and is valid one cycle after a read select.
interface palette_fade_ctrl_if;
    logic        memenable;
    logic [1:0]  memaddr;
    logic        memwrite;
    logic [15:0] writedata;
    logic [15:0] memdata;

    modport master (output memenable, memaddr, memwrite, writedata, input memdata);
    modport slave  (input memenable, memaddr, memwrite, writedata, output memdata);
endinterface

// File: rtl/palette_fade_ctrl.sv
// Palette brightness fader stepped every N vsyncs; optional fade-done irq under PALETTE_FADE_IRQ_EN.
// Latency: commands and steps land on the next edge; read data registered, one cycle after select.
// Backpressure: none, the bus is always accepted; a CONTROL write beats a coincident due step.
module palette_fade_ctrl #(
    parameter logic [7:0] RESET_BRIGHTNESS = 8'hFF,
    parameter logic [7:0] DEFAULT_STEP     = 8'd8,
    parameter logic [7:0] DEFAULT_RATE     = 8'd1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      vsync_pulse,
    palette_fade_ctrl_if.slave        bus,
    output logic [7:0]                brightness,
    output logic                      busy,
    output logic                      irq
);
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_FADE_IN  = 2'b01,
        ST_FADE_OUT = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  bright_q, bright_d;
    logic [7:0]  step_q, step_d;
    logic [7:0]  rate_q, rate_d;
    logic [7:0]  target_q, target_d;
    logic [7:0]  frame_q, frame_d;
    logic        done_q, done_d;
    logic        busy_q;
    logic [15:0] memdata_q, memdata_d;

    logic [7:0]  step_eff, rate_eff, in_next, out_next, step_bright;
    logic [8:0]  sum, diff;
    logic        wr, rd, ctrl_wr, fading;

    always_comb begin
        step_eff = (step_q == 8'd0) ? 8'd1 : step_q;
        rate_eff = (rate_q == 8'd0) ? 8'd1 : rate_q;
        sum      = {1'b0, bright_q} + {1'b0, step_eff};
        diff     = {1'b0, bright_q} - {1'b0, step_eff};
        // Both directions clamp at target so brightness never wraps.
        in_next  = (sum > {1'b0, target_q}) ? target_q : sum[7:0];
        out_next = (diff[8] || (diff[7:0] < target_q)) ? target_q : diff[7:0];
        step_bright = (state_q == ST_FADE_IN) ? in_next : out_next;

        wr      = bus.memenable & bus.memwrite;
        rd      = bus.memenable & ~bus.memwrite;
        ctrl_wr = wr && (bus.memaddr == 2'd0);
        fading  = (state_q == ST_FADE_IN) || (state_q == ST_FADE_OUT);

        state_d   = state_q;
        bright_d  = bright_q;
        step_d    = step_q;
        rate_d    = rate_q;
        target_d  = target_q;
        frame_d   = frame_q;
        done_d    = done_q;
        memdata_d = memdata_q;

        if (rd) begin
            case (bus.memaddr)
                2'd0: memdata_d = {14'h0, state_q};
                2'd1: memdata_d = {rate_q, step_q};
                2'd2: memdata_d = {8'h00, target_q};
                2'd3: memdata_d = {done_q, busy_q, state_q, 4'h0, bright_q};
            endcase
        end

        if (wr) begin
            case (bus.memaddr)
                2'd1: {rate_d, step_d} = bus.writedata;
                2'd2: target_d = bus.writedata[7:0];
                2'd3: if (bus.writedata[15]) done_d = 1'b0;
                default: ;
            endcase
        end

        // Done set is applied after the STATUS clear above so that set wins.
        if (ctrl_wr) begin
            frame_d = 8'd0;
            case (bus.writedata[1:0])
                2'b00: state_d = ST_IDLE;
                2'b01: begin
                    if (target_q <= bright_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FADE_IN;
                    end
                end
                2'b10: begin
                    if (target_q >= bright_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FADE_OUT;
                    end
                end
                2'b11: begin
                    state_d  = ST_IDLE;
                    bright_d = bus.writedata[15:8];
                end
            endcase
        end else if (fading && vsync_pulse) begin
            if (frame_q + 8'd1 == rate_eff) begin
                frame_d  = 8'd0;
                bright_d = step_bright;
                if (step_bright == target_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                frame_d = frame_q + 8'd1;
            end
        end else if (!fading) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bright_q  <= RESET_BRIGHTNESS;
            step_q    <= DEFAULT_STEP;
            rate_q    <= DEFAULT_RATE;
            target_q  <= 8'h00;
            frame_q   <= 8'd0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            memdata_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            bright_q  <= bright_d;
            step_q    <= step_d;
            rate_q    <= rate_d;
            target_q  <= target_d;
            frame_q   <= frame_d;
            done_q    <= done_d;
            busy_q    <= (state_d == ST_FADE_IN) || (state_d == ST_FADE_OUT);
            memdata_q <= memdata_d;
        end
    end

    assign brightness  = bright_q;
    assign busy        = busy_q;
    assign bus.memdata = memdata_q;

`ifdef PALETTE_FADE_IRQ_EN
    assign irq = done_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// Directed and random checks of palette_fade_ctrl against a plain-arithmetic fade model.
module tb_palette_fade_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       vsync_pulse;
    logic [7:0] brightness;
    logic       busy;
    logic       irq;

    palette_fade_ctrl_if bus_if();

    palette_fade_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vsync_pulse (vsync_pulse),
        .bus         (bus_if),
        .brightness  (brightness),
        .busy        (busy),
        .irq         (irq)
    );

    always #5 clk = ~clk;

`ifdef PALETTE_FADE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    localparam logic [1:0] A_CTRL = 2'd0, A_RS = 2'd1, A_TGT = 2'd2, A_STAT = 2'd3;

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode 0 idle, 1 fading in, 2 fading out.
    int m_bright, m_step, m_rate, m_target, m_mode, m_fcnt;
    bit m_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bright = 255; m_step = 8; m_rate = 1; m_target = 0;
        m_mode = 0; m_fcnt = 0; m_done = 0;
    endtask

    function automatic logic [15:0] model_read(input logic [1:0] a);
        logic [15:0] v;
        case (a)
            2'd0: v = {14'h0, m_mode[1:0]};
            2'd1: v = {m_rate[7:0], m_step[7:0]};
            2'd2: v = {8'h00, m_target[7:0]};
            default: v = {m_done, (m_mode != 0), m_mode[1:0], 4'h0, m_bright[7:0]};
        endcase
        return v;
    endfunction

    task automatic model_cycle(input bit en, input bit wr, input logic [1:0] a,
                               input logic [15:0] wd, input bit vs);
        bit set_done = 0;
        int s, r;
        if (en && wr && a == A_CTRL) begin
            m_fcnt = 0;
            case (wd[1:0])
                2'b00: m_mode = 0;
                2'b01: if (m_target <= m_bright) begin m_mode = 0; set_done = 1; end else m_mode = 1;
                2'b10: if (m_target >= m_bright) begin m_mode = 0; set_done = 1; end else m_mode = 2;
                default: begin m_mode = 0; m_bright = int'(wd[15:8]); end
            endcase
        end else if (m_mode != 0 && vs) begin
            r = (m_rate == 0) ? 1 : m_rate;
            s = (m_step == 0) ? 1 : m_step;
            m_fcnt = (m_fcnt + 1) % 256;
            if (m_fcnt == r) begin
                m_fcnt = 0;
                if (m_mode == 1) m_bright = (m_bright + s > m_target) ? m_target : m_bright + s;
                else             m_bright = (m_bright - s < m_target) ? m_target : m_bright - s;
                if (m_bright == m_target) begin m_mode = 0; set_done = 1; end
            end
        end
        if (en && wr) begin
            case (a)
                A_RS:   begin m_rate = int'(wd[15:8]); m_step = int'(wd[7:0]); end
                A_TGT:  m_target = int'(wd[7:0]);
                A_STAT: if (wd[15]) m_done = 0;
                default: ;
            endcase
        end
        if (set_done) m_done = 1;
    endtask

    // One clock of stimulus; outputs compared #1 after the edge.
    task automatic cyc(input bit en, input bit wr, input logic [1:0] a,
                       input logic [15:0] wd, input bit vs, input string tag);
        logic [15:0] exp_rd;
        bus_if.memenable = en; bus_if.memwrite = wr; bus_if.memaddr = a;
        bus_if.writedata = wd; vsync_pulse = vs;
        exp_rd = model_read(a);
        @(posedge clk); #1;
        model_cycle(en, wr, a, wd, vs);
        bus_if.memenable = 1'b0; bus_if.memwrite = 1'b0; vsync_pulse = 1'b0;
        check({tag, "_bright"}, 32'(brightness), 32'(m_bright));
        check({tag, "_busy"}, 32'(busy), 32'(m_mode != 0));
        check({tag, "_irq"}, 32'(irq), 32'(IRQ_EN & m_done));
        if (en && !wr) check({tag, "_rd"}, 32'(bus_if.memdata), 32'(exp_rd));
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
        cyc(1'b1, 1'b1, a, d, 1'b0, "wr");
    endtask

    task automatic rd_expect(input logic [1:0] a, input logic [15:0] exp, input string tag);
        cyc(1'b1, 1'b0, a, 16'h0, 1'b0, tag);
        check(tag, 32'(bus_if.memdata), 32'(exp));
    endtask

    task automatic vsync_cycle(input string tag);
        cyc(1'b0, 1'b0, A_CTRL, 16'h0, 1'b1, tag);
    endtask

    logic [7:0] tbl_in  [4] = '{8'h40, 8'h80, 8'hC0, 8'hFF};
    logic [7:0] tbl_out [9] = '{8'h28, 8'h28, 8'h18, 8'h18, 8'h18, 8'h08, 8'h08, 8'h08, 8'h00};

    initial begin
        rst_n = 1'b0; vsync_pulse = 1'b0;
        bus_if.memenable = 1'b0; bus_if.memwrite = 1'b0;
        bus_if.memaddr = 2'd0; bus_if.writedata = 16'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_bright", 32'(brightness), 32'hFF);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        rd_expect(A_STAT, 16'h00FF, "rst_status");
        rd_expect(A_RS, 16'h0108, "rst_ratestep");
        rd_expect(A_TGT, 16'h0000, "rst_target");

        // Fade in 00 -> FF in four steps of 0x40.
        wr_reg(A_CTRL, 16'h0003);
        wr_reg(A_RS, 16'h0140);
        wr_reg(A_TGT, 16'h00FF);
        wr_reg(A_CTRL, 16'h0001);
        check("fadein_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 4; i++) begin
            vsync_cycle("fadein_vs");
            check("fadein_step", 32'(brightness), 32'(tbl_in[i]));
        end
        rd_expect(A_STAT, 16'h80FF, "fadein_done_status");
        check("fadein_irq", 32'(irq), 32'(IRQ_EN));
        wr_reg(A_STAT, 16'h8000);
        check("irq_cleared", 32'(irq), 32'h0);
        rd_expect(A_STAT, 16'h00FF, "status_cleared");

        // Fade out 28 -> 00, step 0x10 every third vsync.
        wr_reg(A_CTRL, 16'h2803);
        wr_reg(A_RS, 16'h0310);
        wr_reg(A_TGT, 16'h0000);
        wr_reg(A_CTRL, 16'h0002);
        for (int i = 0; i < 9; i++) begin
            vsync_cycle("fadeout_vs");
            check("fadeout_step", 32'(brightness), 32'(tbl_out[i]));
            cyc(1'b0, 1'b0, A_CTRL, 16'h0, 1'b0, "fadeout_gap");
        end
        rd_expect(A_STAT, 16'h8000, "fadeout_done_status");
        wr_reg(A_STAT, 16'h8000);

        // FADE_OUT toward a target above current brightness finishes at once.
        wr_reg(A_CTRL, 16'h3003);
        wr_reg(A_TGT, 16'h0050);
        wr_reg(A_CTRL, 16'h0002);
        check("noop_busy", 32'(busy), 32'h0);
        check("noop_bright", 32'(brightness), 32'h30);
        rd_expect(A_STAT, 16'h8030, "noop_status");
        wr_reg(A_STAT, 16'h8000);

        // CONTROL write coincident with a due step: no step, frame count restarts.
        wr_reg(A_CTRL, 16'h0003);
        wr_reg(A_RS, 16'h0220);
        wr_reg(A_TGT, 16'h00FF);
        wr_reg(A_CTRL, 16'h0001);
        vsync_cycle("coinc_pre");
        cyc(1'b1, 1'b1, A_CTRL, 16'h0001, 1'b1, "coinc");
        check("coinc_bright", 32'(brightness), 32'h00);
        check("coinc_busy", 32'(busy), 32'h1);
        vsync_cycle("coinc_vs1");
        check("coinc_nostep", 32'(brightness), 32'h00);
        vsync_cycle("coinc_vs2");
        check("coinc_step", 32'(brightness), 32'h20);
        rd_expect(A_CTRL, 16'h0001, "coinc_ctrl");

        // Asynchronous reset in the middle of the fade.
        #2 rst_n = 1'b0;
        #1;
        check("midrst_bright", 32'(brightness), 32'hFF);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_expect(A_STAT, 16'h00FF, "midrst_status");

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            int r;
            logic [1:0]  a;
            logic [15:0] d;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                cyc(1'b0, 1'b0, A_CTRL, 16'h0, ($urandom_range(0, 2) == 0), "rnd_idle");
            end else begin
                a = 2'($urandom_range(0, 3));
                d = 16'($urandom);
                if (a == A_RS) d[15:8] = 8'($urandom_range(0, 3));
                cyc(1'b1, ($urandom_range(0, 1) == 1), a, d, ($urandom_range(0, 3) == 0), "rnd_bus");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
